bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per cycle.
Sits directly downstream of the divider and the other arithmetic units in the calculator datapath. It converts a BITS-wide result into packed decimal digits for the display driver.
Uses the same start/rdy handshake as the divider, so its start can be pulsed straight from the divider's rdy edge.

Parameters:
BITS, 32, width of binary input.
DIGITS, 10, number of BCD output digits; must satisfy 10^DIGITS > 2^BITS - 1, otherwise elaboration fails with an error.
SIGNED, 0, 1 = input is two's complement (sign reported separately, magnitude converted); 0 = unsigned.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; bin sampled on the same edge
bin  input  BITS  binary value to convert
bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]
neg  output  1  1 = input was negative (SIGNED=1 only; constant 0 when SIGNED=0)
ndigits  output  clog2(DIGITS+1)  count of significant digits, minimum 1
rdy  output  1  result valid; held until next start or rst

Behaviour:
- Reset state (rst=1 at an edge): IDLE, bcd=0, neg=0, ndigits=1, rdy=0. rst has priority over start.
- States: IDLE, CONV, COUNT, DONE.
- start sampled high in any state (including CONV/COUNT), edge E0:
  - Load the magnitude into the shift register: if SIGNED and bin[BITS-1], load 0 - bin, else bin.
  - Latch the sign into an internal neg_tmp.
  - Clear the BCD work register; iteration counter = BITS-1; rdy<=0; state CONV.
- Magnitude width: the magnitude is BITS-bit unsigned, so -2^(BITS-1) converts correctly to 2^(BITS-1).
- CONV, one iteration per edge:
  - Every work digit >= 5 gets +3.
  - Then {work, shift} shifts left by 1, MSB of shift entering work digit 0.
  - Counter decrements; on the edge with counter==0, go to COUNT.
- COUNT, one edge:
  - bcd <= work; neg <= neg_tmp.
  - ndigits <= 1 + index of the highest nonzero digit (1 if all zero).
  - rdy <= 1; state DONE.
- DONE: hold all outputs; only start or rst leaves this state.
- Latency: rdy rises on edge E0+BITS+1 (33 edges after the start edge for BITS=32).
- Output stability: bcd/neg/ndigits keep their previous values throughout CONV. They change only on the COUNT edge or on rst.
- Abort on start: start during CONV/COUNT aborts the current conversion and restarts with the new bin. No rdy pulse is produced for the aborted value.
- Reset mid-operation: the next cycle shows reset values; rdy stays 0 until a new start completes.
- Work digits never exceed 9 after adjust. No overflow is possible given the DIGITS constraint.
- rdy is registered and has no combinational path from start.

Decomposition:
- Shared include fpgacalc_defs.vh holds:
  - the clog2 function (same definition used by div);
  - the BCD_W=4 constant;
  - the state encodings for bin2bcd_seq.
- One sub-module, bcd_dabble_digit: combinational 4-bit "if >=5 add 3" adjust, instantiated DIGITS times via generate.
- Counter, shift register and FSM stay in the top module.

Test Plan:
1. Zero input: rst 2 cycles, start with bin=0 (SIGNED=0) -> rdy=1 exactly 33 edges after the start edge; bcd=0, ndigits=1, neg=0.
2. Maximum unsigned: bin=32'hFFFFFFFF (SIGNED=0) -> bcd digits 4294967295 (bcd=40'h4294967295), ndigits=10, neg=0.
3. Signed negative: SIGNED=1, bin=32'hFFFFFF85 (-123) -> neg=1, bcd=40'h0000000123, ndigits=3. Also bin=32'h80000000 -> neg=1, bcd=40'h2147483648, ndigits=10.
4. Restart: start bin=1234, start again with bin=56 ten edges later -> rdy stays 0 until 33 edges after the second start; then bcd=40'h56, ndigits=2. bcd keeps its prior value throughout.
5. Reset mid-op: start bin=999, assert rst at edge 5 -> next cycle rdy=0, bcd=0, ndigits=1; no rdy ever appears. Also start and rst high on the same edge -> reset values, stays IDLE.
6. Hold and back-to-back: after rdy, hold start=0 for 50 cycles -> outputs and rdy stable. Then start with bin=10 -> rdy falls on that edge; after 33 edges bcd=40'h10, ndigits=2.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit width, FSM state encodings and elaboration-time helper functions.
package bin2bcd_seq_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Smallest r such that 2**r >= value (bounded loop, constant-foldable).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of decimal digits needed to hold 2**bits - 1 (at least 1).
    // Exact 256-bit arithmetic, so valid for bits up to 200.
    function automatic int min_digits(input int bits);
        logic [255:0] lim;
        logic [255:0] p;
        int           d;
        lim = (256'd1 << bits) - 256'd1;
        p   = 256'd1;
        d   = 0;
        for (int i = 0; i < 80; i++) begin
            if (p <= lim) begin
                p = p * 256'd10;
                d = d + 1;
            end
        end
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle of the binary-to-BCD converter. The requester drives
// start/bin; the converter returns packed BCD, sign, digit count and rdy.
interface bin2bcd_seq_if #(
    parameter int BITS   = 32,
    parameter int DIGITS = 10
);
    import bin2bcd_seq_pkg::*;

    localparam int NDIG_W = clog2(DIGITS + 1);

    logic                      start;
    logic [BITS-1:0]           bin;
    logic [BCD_W*DIGITS-1:0]   bcd;
    logic                      neg;
    logic [NDIG_W-1:0]         ndigits;
    logic                      rdy;

    modport master (
        output start, bin,
        input  bcd, neg, ndigits, rdy
    );

    modport slave (
        input  start, bin,
        output bcd, neg, ndigits, rdy
    );

endinterface

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit correction: any digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_dabble_digit
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] d_i,
    output logic [BCD_W-1:0] d_o
);

    // Add-3 adjust; inputs are always 0..9 so the result stays within 4 bits.
    always_comb begin
        d_o = (d_i >= BCD_W'(5)) ? (d_i + BCD_W'(3)) : d_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// cycle. A start in any state (re)loads the operands; results appear one
// cycle after the last shift and are held with rdy until the next start.
module bin2bcd_seq #(
    parameter int BITS   = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    import bin2bcd_seq_pkg::*;

    localparam int WORK_W = BCD_W * DIGITS;
    localparam int NDIG_W = clog2(DIGITS + 1);
    localparam int CNT_W  = (BITS > 1) ? clog2(BITS) : 1;

    // Refuse to build a converter whose digit register could overflow.
    if (BITS > 200) begin : g_bits_chk
        $error("bin2bcd_seq: BITS=%0d exceeds the supported maximum of 200", BITS);
    end
    if (DIGITS < min_digits(BITS)) begin : g_digits_chk
        $error("bin2bcd_seq: DIGITS=%0d cannot hold 2**%0d-1 (needs %0d)",
               DIGITS, BITS, min_digits(BITS));
    end

    logic [1:0]             state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [BITS-1:0]        shift_q,   shift_d;
    logic [WORK_W-1:0]      work_q,    work_d;
    logic                   neg_tmp_q, neg_tmp_d;
    logic [WORK_W-1:0]      bcd_q,     bcd_d;
    logic                   neg_q,     neg_d;
    logic [NDIG_W-1:0]      ndig_q,    ndig_d;
    logic                   rdy_q,     rdy_d;

    logic [WORK_W-1:0]      work_adj;
    logic signed [BITS-1:0] bin_s;
    logic                   bin_neg;
    logic [BITS-1:0]        mag;

    // Magnitude is BITS-bit unsigned, so the most negative input maps to
    // 2**(BITS-1) without overflow.
    assign bin_s   = $signed(bus.bin);
    assign bin_neg = (SIGNED != 0) && bus.bin[BITS-1];
    assign mag     = bin_neg ? $unsigned(-bin_s) : bus.bin;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_dabble_digit u_digit (
            .d_i (work_q[g*BCD_W +: BCD_W]),
            .d_o (work_adj[g*BCD_W +: BCD_W])
        );
    end

    // 1 + index of the highest nonzero digit; 1 when the value is zero.
    function automatic logic [NDIG_W-1:0] sig_digits(input logic [WORK_W-1:0] w);
        logic [NDIG_W-1:0] n;
        n = NDIG_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (w[i*BCD_W +: BCD_W] != '0) begin
                n = NDIG_W'(i + 1);
            end
        end
        return n;
    endfunction

    // Next-state logic: start overrides everything, otherwise step the FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        work_d    = work_q;
        neg_tmp_d = neg_tmp_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ndig_d    = ndig_q;
        rdy_d     = rdy_q;

        if (bus.start) begin
            shift_d   = mag;
            neg_tmp_d = bin_neg;
            work_d    = '0;
            cnt_d     = CNT_W'(BITS - 1);
            rdy_d     = 1'b0;
            state_d   = S_CONV;
        end else begin
            case (state_q)
                S_CONV: begin
                    // Adjusted digits and the shift register move left as one
                    // long word; the top work bit is always zero here.
                    work_d  = WORK_W'({work_adj, shift_q[BITS-1]});
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_COUNT;
                    end
                end
                S_COUNT: begin
                    bcd_d   = work_q;
                    neg_d   = neg_tmp_q;
                    ndig_d  = sig_digits(work_q);
                    rdy_d   = 1'b1;
                    state_d = S_DONE;
                end
                default: begin
                    // IDLE and DONE hold until the next start.
                end
            endcase
        end
    end

    // Control and visible outputs: reset to the idle, empty-result state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ndig_q  <= NDIG_W'(1);
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ndig_q  <= ndig_d;
            rdy_q   <= rdy_d;
        end
    end

    // Working datapath: only meaningful after a start, so left unreset.
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        shift_q   <= shift_d;
        work_q    <= work_d;
        neg_tmp_q <= neg_tmp_d;
    end

    assign bus.bcd     = bcd_q;
    assign bus.neg     = neg_q;
    assign bus.ndigits = ndig_q;
    assign bus.rdy     = rdy_q;

endmodule
